dsc_mul_n: RTL

- Deterministic stochastic-computing multiplier for NUM_IN unsigned operands of WIDTH bits each.
- Each operand drives a counter-based unary stream generator. The generators are chained so that every combination of counter states occurs exactly once per run.
- The AND of all streams is counted, giving the exact integer product.
- Single-clock replacement for the fixed 3-input, 4-bit multiplier with ripple-clocked generators. Adds a start/busy/done handshake, operand latching and parametrised operand count and width.

---
 rtl/dsc_mul_n.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/dsc_mul_n.sv
`default_nettype none
// ============================================================================
//  Module      : dsc_mul_n
//  Description : Deterministic stochastic-computing multiplier. NUM_IN
//                unsigned WIDTH-bit operands each drive a counter-based unary
//                stream generator. The counters form an odometer, so every
//                combination of counter states occurs exactly once per run.
//                The ANDed streams are counted, which gives the exact integer
//                product after 2^(NUM_IN*WIDTH) cycles.
//
//  Ports       : clk      - sole clock, rising edge
//                rst      - synchronous active-high reset
//                start    - run request, seen only in IDLE or DONE
//                operands - packed operands, operand i at [i*WIDTH +: WIDTH]
//                z        - registered product, updated on DONE entry
//                busy     - high while a run is in progress
//                done     - one-cycle pulse when z has been updated
//
//  Revision    : 1.0 - initial release
// ============================================================================
module dsc_mul_n #(
    parameter int WIDTH  = 4,
    parameter int NUM_IN = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [NUM_IN*WIDTH-1:0]   operands,
    output logic [NUM_IN*WIDTH-1:0]   z,
    output logic                      busy,
    output logic                      done
);

    // Result and accumulator width. The largest possible product,
    // (2^WIDTH-1)^NUM_IN, always fits below 2^ZW.
    localparam int ZW = NUM_IN * WIDTH;

    localparam logic [WIDTH-1:0] c_cnt_max = {WIDTH{1'b1}};

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_run  = 2'd1;
    localparam logic [1:0] c_st_done = 2'd2;

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;

    logic              w_run;
    logic              w_accept;
    logic              w_and;
    logic              w_last;
    logic [NUM_IN-1:0] w_stream;
    // w_carry[i] is the enable for counter i: every lower counter sits at its
    // maximum. w_carry[NUM_IN] therefore marks the final odometer state.
    logic [NUM_IN:0]   w_carry;

    logic [ZW-1:0]     r_acc;
    logic [ZW-1:0]     w_acc_sum;
    logic [ZW-1:0]     r_z;

    assign w_run    = (r_state == c_st_run);
    // A start is only honoured when no run is in flight.
    assign w_accept = start && ((r_state == c_st_idle) || (r_state == c_st_done));

    assign w_carry[0] = 1'b1;

    // ------------------------------------------------------------------------
    // Stream generators: one latched operand and one counter per input.
    // ------------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_gen
            logic [WIDTH-1:0] r_op;
            logic [WIDTH-1:0] r_cnt;

            // Unary stream: high for op of the 2^WIDTH counter states.
            assign w_stream[gi]    = (r_cnt < r_op);
            assign w_carry[gi + 1] = w_carry[gi] && (r_cnt == c_cnt_max);

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_op  <= '0;
                    r_cnt <= '0;
                end else if (w_accept) begin
                    r_op  <= operands[gi*WIDTH +: WIDTH];
                    r_cnt <= '0;
                end else if (w_run && w_carry[gi]) begin
                    // Wraps naturally to zero after the maximum.
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    endgenerate

    assign w_and  = &w_stream;
    assign w_last = w_carry[NUM_IN];

    // The bit of the current cycle is added in, so the final edge can write
    // the complete product straight into z without an extra cycle.
    assign w_acc_sum = r_acc + {{(ZW-1){1'b0}}, w_and};

    // ------------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle: begin
                if (start) begin
                    w_state_nxt = c_st_run;
                end
            end
            c_st_run: begin
                if (w_last) begin
                    w_state_nxt = c_st_done;
                end
            end
            c_st_done: begin
                // start here launches a back-to-back run with no idle cycle.
                if (start) begin
                    w_state_nxt = c_st_run;
                end else begin
                    w_state_nxt = c_st_idle;
                end
            end
            default: begin
                w_state_nxt = c_st_idle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Accumulator and result register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc <= '0;
        end else if (w_accept) begin
            r_acc <= '0;
        end else if (w_run) begin
            r_acc <= w_acc_sum;
        end
    end

    // z only moves on DONE entry (or reset); it holds the previous product
    // for the whole of a run.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_z <= '0;
        end else if (w_run && w_last) begin
            r_z <= w_acc_sum;
        end
    end

    assign z    = r_z;
    assign busy = w_run;
    assign done = (r_state == c_st_done);

endmodule
`default_nettype wire
